// File: rtl/scsp_dma_ctrl.sv
// SCSP sound-side DMA sequencer: moves 16-bit words between sound RAM and the
// SCSP register space through request/acknowledge bus handshakes.
module scsp_dma_ctrl #(
  parameter int RAM_AW = 19,
  parameter int REG_AW = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              cr_wr,
  input  logic [1:0]        cr_sel,
  input  logic [15:0]       cr_di,
  output logic [15:0]       cr7_do,
  output logic [RAM_AW-1:0] ram_a,
  output logic [15:0]       ram_d,
  input  logic [15:0]       ram_q,
  output logic              ram_req,
  output logic              ram_we,
  input  logic              ram_ack,
  output logic [REG_AW-1:0] reg_a,
  output logic [15:0]       reg_d,
  input  logic [15:0]       reg_q,
  output logic              reg_req,
  output logic              reg_we,
  input  logic              reg_ack,
  output logic              busy,
  output logic              dma_end
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} state_t;

  state_t state_q, state_d;

  logic [14:0]       dmeal;
  logic [3:0]        dmeah;
  logic [10:0]       drga;
  logic [10:0]       dtlg;
  logic              dgate, ddir, dexe;

  logic [RAM_AW-1:0] raddr;
  logic [REG_AW-1:0] gaddr;
  logic [10:0]       count;
  logic [15:0]       data;

  logic              cr_en, start, acc_ack, latch, step;
  logic [15:0]       wdata;
  logic              unused;

  // Control registers are frozen for the whole transfer, including DONE.
  assign cr_en  = ce && cr_wr && !dexe;
  assign start  = cr_en && (cr_sel == 2'd2) && cr_di[12];
  assign wdata  = dgate ? 16'h0000 : data;

  assign ram_a  = raddr;
  assign reg_a  = gaddr;
  assign ram_d  = wdata;
  assign reg_d  = wdata;
  assign busy   = dexe;
  assign cr7_do = {1'b0, dgate, ddir, dexe, 12'h000};

  // DTLG has no readback path; the start write feeds the counter directly.
  assign unused = ^{dtlg, cr_di[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ram_req = 1'b0;
    ram_we  = 1'b0;
    reg_req = 1'b0;
    reg_we  = 1'b0;
    acc_ack = 1'b0;
    latch   = 1'b0;
    step    = 1'b0;
    dma_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cr_di[11:1] == 11'd0) state_d = ST_DONE;
          else if (cr_di[14])       state_d = ST_WR;
          else                      state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (ddir) begin
          reg_req = 1'b1;
          acc_ack = reg_ack;
        end else begin
          ram_req = 1'b1;
          acc_ack = ram_ack;
        end
        if (acc_ack) begin
          latch   = 1'b1;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (ddir) begin
          ram_req = 1'b1;
          ram_we  = 1'b1;
          acc_ack = ram_ack;
        end else begin
          reg_req = 1'b1;
          reg_we  = 1'b1;
          acc_ack = reg_ack;
        end
        if (acc_ack) begin
          step = 1'b1;
          if (count <= 11'd1) state_d = ST_DONE;
          else if (dgate)     state_d = ST_WR;
          else                state_d = ST_RD;
        end
      end
      ST_DONE: begin
        dma_end = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmeal <= '0;
      dmeah <= '0;
      drga  <= '0;
      dtlg  <= '0;
      dgate <= 1'b0;
      ddir  <= 1'b0;
      dexe  <= 1'b0;
      raddr <= '0;
      gaddr <= '0;
      count <= '0;
      data  <= '0;
    end else if (ce) begin
      if (cr_en) begin
        case (cr_sel)
          2'd0: dmeal <= cr_di[15:1];
          2'd1: begin
            dmeah <= cr_di[15:12];
            drga  <= cr_di[11:1];
          end
          2'd2: begin
            dgate <= cr_di[14];
            ddir  <= cr_di[13];
            dexe  <= cr_di[12];
            dtlg  <= cr_di[11:1];
          end
          default: ;
        endcase
      end
      // Working copies advance; the programmed DMEA/DRGA/DTLG stay intact.
      if (start) begin
        raddr <= RAM_AW'({dmeah, dmeal});
        gaddr <= REG_AW'(drga);
        count <= cr_di[11:1];
      end
      if (latch) data <= ddir ? reg_q : ram_q;
      if (step) begin
        raddr <= raddr + 1'b1;
        gaddr <= gaddr + 1'b1;
        if (count != 11'd0) count <= count - 1'b1;
      end
      if (state_q == ST_DONE) dexe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scsp_dma_ctrl.sv
// Directed bench for scsp_dma_ctrl: bus responders with configurable latency
// log every completed access, and each scenario task checks the log and timing.
module tb_scsp_dma_ctrl;
  localparam int RAM_AW = 19;
  localparam int REG_AW = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ce = 1'b1;
  logic              cr_wr = 1'b0;
  logic [1:0]        cr_sel = 2'd3;
  logic [15:0]       cr_di = 16'h0;
  logic [15:0]       cr7_do;
  logic [RAM_AW-1:0] ram_a;
  logic [15:0]       ram_d;
  logic [15:0]       ram_q = 16'h0;
  logic              ram_req, ram_we;
  logic              ram_ack = 1'b0;
  logic [REG_AW-1:0] reg_a;
  logic [15:0]       reg_d;
  logic [15:0]       reg_q = 16'h0;
  logic              reg_req, reg_we;
  logic              reg_ack = 1'b0;
  logic              busy, dma_end;

  typedef struct packed {
    logic        ram;
    logic        we;
    logic [31:0] addr;
    logic [15:0] data;
  } acc_t;

  acc_t log_q[$];
  acc_t exp_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, start_cyc = 0, end_cnt = 0, req_seen = 0, stable_err = 0;
  int ram_lat = 0, reg_lat = 0, ram_cnt = 0, reg_cnt = 0;
  logic [RAM_AW-1:0] ram_a0;
  logic [REG_AW-1:0] reg_a0;
  logic              ram_we0, reg_we0;
  logic [15:0]       ram_d0, reg_d0;

  scsp_dma_ctrl #(.RAM_AW(RAM_AW), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .cr_wr(cr_wr), .cr_sel(cr_sel),
    .cr_di(cr_di), .cr7_do(cr7_do), .ram_a(ram_a), .ram_d(ram_d),
    .ram_q(ram_q), .ram_req(ram_req), .ram_we(ram_we), .ram_ack(ram_ack),
    .reg_a(reg_a), .reg_d(reg_d), .reg_q(reg_q), .reg_req(reg_req),
    .reg_we(reg_we), .reg_ack(reg_ack), .busy(busy), .dma_end(dma_end)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [15:0] ram_val(input logic [RAM_AW-1:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] reg_val(input logic [REG_AW-1:0] a);
    return {5'h00, a} ^ 16'h5A00;
  endfunction

  // Responders: ACK asserted on the falling edge so the DUT samples it next rise.
  always @(negedge clk) begin
    if (dma_end) end_cnt++;
    if (ram_req) begin
      req_seen++;
      if (ram_cnt == 0) begin
        ram_a0 = ram_a; ram_we0 = ram_we; ram_d0 = ram_d;
      end else if (ram_a !== ram_a0 || ram_we !== ram_we0 || (ram_we && ram_d !== ram_d0)) begin
        stable_err++;
      end
      if (ram_cnt >= ram_lat) begin
        ram_ack = 1'b1;
        ram_q   = ram_we ? 16'h0000 : ram_val(ram_a);
        log_q.push_back({1'b1, ram_we, 32'(ram_a), ram_we ? ram_d : ram_val(ram_a)});
        ram_cnt = 0;
      end else begin
        ram_ack = 1'b0;
        ram_cnt++;
      end
    end else begin
      if (ram_cnt != 0) stable_err++;
      ram_ack = 1'b0;
      ram_cnt = 0;
    end
    if (reg_req) begin
      req_seen++;
      if (reg_cnt == 0) begin
        reg_a0 = reg_a; reg_we0 = reg_we; reg_d0 = reg_d;
      end else if (reg_a !== reg_a0 || reg_we !== reg_we0 || (reg_we && reg_d !== reg_d0)) begin
        stable_err++;
      end
      if (reg_cnt >= reg_lat) begin
        reg_ack = 1'b1;
        reg_q   = reg_we ? 16'h0000 : reg_val(reg_a);
        log_q.push_back({1'b0, reg_we, 32'(reg_a), reg_we ? reg_d : reg_val(reg_a)});
        reg_cnt = 0;
      end else begin
        reg_ack = 1'b0;
        reg_cnt++;
      end
    end else begin
      if (reg_cnt != 0) stable_err++;
      reg_ack = 1'b0;
      reg_cnt = 0;
    end
  end

  task automatic cr_write(input logic [1:0] sel, input logic [15:0] d);
    @(negedge clk);
    cr_wr = 1'b1; cr_sel = sel; cr_di = d;
    @(negedge clk);
    cr_wr = 1'b0; cr_sel = 2'd3; cr_di = 16'h0;
  endtask

  task automatic start7(input logic [15:0] d);
    log_q.delete(); exp_q.delete();
    req_seen = 0; stable_err = 0;
    cr_write(2'd2, d);
    start_cyc = cyc;
  endtask

  // k = 1 for the first sample after the start edge; -1 when the bound expires.
  task automatic wait_end(output int k);
    k = -1;
    for (int n = 0; n < 300; n++) begin
      if (dma_end) begin
        k = cyc - start_cyc + 1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cr7_do, ram_a, ram_d, ram_req, ram_we, reg_a, reg_d, reg_req, reg_we, busy, dma_end} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0", {cr7_do, ram_a, ram_d, ram_req, reg_a, reg_d, reg_req, busy, dma_end});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cr7_do, ram_req, reg_req, busy, dma_end} !== '0) begin
      failures++;
      $display("FAIL reset_release: got %h required 0", {cr7_do, ram_req, reg_req, busy, dma_end});
    end
  endtask

  task automatic test_ram_to_reg;
    int k, n;
    cr_write(2'd0, 16'h0200);
    cr_write(2'd1, 16'h0400);
    start7(16'h1006);
    checks++;
    if ({busy, ram_req, reg_req, cr7_do} !== {3'b110, 16'h1000}) begin
      failures++;
      $display("FAIL r2g_first_req: got %h required %h", {busy, ram_req, reg_req, cr7_do}, {3'b110, 16'h1000});
    end
    wait_end(k);
    checks++;
    if (k != 7) begin
      failures++;
      $display("FAIL r2g_end_time: got %0d required 7", k);
    end
    @(negedge clk);
    checks++;
    if ({dma_end, busy, cr7_do} !== 18'h0) begin
      failures++;
      $display("FAIL r2g_after: got %h required 0", {dma_end, busy, cr7_do});
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b1, 1'b0, 32'h100 + 32'(i), ram_val(19'(32'h100 + i))});
      exp_q.push_back({1'b0, 1'b1, 32'h200 + 32'(i), ram_val(19'(32'h100 + i))});
    end
    checks++;
    if (log_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL r2g_count: got %0d required %0d", log_q.size(), exp_q.size());
    end
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL r2g_acc%0d: got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reg_to_ram;
    int k, n;
    cr_write(2'd0, 16'h0600);
    cr_write(2'd1, 16'h0080);
    start7(16'h3004);
    wait_end(k);
    checks++;
    if (k != 5) begin
      failures++;
      $display("FAIL g2r_end_time: got %0d required 5", k);
    end
    @(negedge clk);
    checks++;
    if (cr7_do !== 16'h2000) begin
      failures++;
      $display("FAIL g2r_cr7: got %h required 2000", cr7_do);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, 1'b0, 32'h40 + 32'(i), reg_val(11'(32'h40 + i))});
      exp_q.push_back({1'b1, 1'b1, 32'h300 + 32'(i), reg_val(11'(32'h40 + i))});
    end
    checks++;
    if (log_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL g2r_count: got %0d required %0d", log_q.size(), exp_q.size());
    end
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL g2r_acc%0d: got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_gate;
    int k, n;
    start7(16'h7004);
    checks++;
    if (cr7_do !== 16'h7000) begin
      failures++;
      $display("FAIL gate_cr7_busy: got %h required 7000", cr7_do);
    end
    wait_end(k);
    checks++;
    if (k != 3) begin
      failures++;
      $display("FAIL gate_end_time: got %0d required 3", k);
    end
    @(negedge clk);
    checks++;
    if (cr7_do !== 16'h6000) begin
      failures++;
      $display("FAIL gate_cr7_done: got %h required 6000", cr7_do);
    end
    exp_q.push_back({1'b1, 1'b1, 32'h300, 16'h0000});
    exp_q.push_back({1'b1, 1'b1, 32'h301, 16'h0000});
    checks++;
    if (log_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL gate_count: got %0d required %0d", log_q.size(), exp_q.size());
    end
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL gate_acc%0d: got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap;
    int k, n;
    cr_write(2'd0, 16'hFFFE);
    cr_write(2'd1, 16'hFFFE);
    start7(16'h1004);
    wait_end(k);
    checks++;
    if (k != 5) begin
      failures++;
      $display("FAIL wrap_end_time: got %0d required 5", k);
    end
    @(negedge clk);
    exp_q.push_back({1'b1, 1'b0, 32'h7FFFF, ram_val(19'h7FFFF)});
    exp_q.push_back({1'b0, 1'b1, 32'h7FF,   ram_val(19'h7FFFF)});
    exp_q.push_back({1'b1, 1'b0, 32'h00000, ram_val(19'h00000)});
    exp_q.push_back({1'b0, 1'b1, 32'h000,   ram_val(19'h00000)});
    checks++;
    if (log_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL wrap_count: got %0d required %0d", log_q.size(), exp_q.size());
    end
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL wrap_acc%0d: got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_len;
    int k;
    start7(16'h1000);
    wait_end(k);
    checks++;
    if (k != 1) begin
      failures++;
      $display("FAIL zero_end_time: got %0d required 1", k);
    end
    @(negedge clk);
    checks++;
    if ({dma_end, busy} !== 2'b00) begin
      failures++;
      $display("FAIL zero_pulse: got %b required 00", {dma_end, busy});
    end
    checks++;
    if (req_seen != 0) begin
      failures++;
      $display("FAIL zero_no_req: got %0d required 0", req_seen);
    end
  endtask

  task automatic test_busy_write;
    int k, n;
    cr_write(2'd0, 16'h00A0);
    cr_write(2'd1, 16'h0020);
    ram_lat = 3;
    start7(16'h1004);
    cr_write(2'd0, 16'hFFFE);
    cr_write(2'd1, 16'hFFFE);
    cr_write(2'd2, 16'h7FFE);
    checks++;
    if (cr7_do !== 16'h1000) begin
      failures++;
      $display("FAIL busy_cr7: got %h required 1000", cr7_do);
    end
    wait_end(k);
    checks++;
    if (k != 11) begin
      failures++;
      $display("FAIL busy_end_time: got %0d required 11", k);
    end
    @(negedge clk);
    checks++;
    if (stable_err != 0) begin
      failures++;
      $display("FAIL busy_stable: got %0d unstable cycles required 0", stable_err);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b1, 1'b0, 32'h50 + 32'(i), ram_val(19'(32'h50 + i))});
      exp_q.push_back({1'b0, 1'b1, 32'h10 + 32'(i), ram_val(19'(32'h50 + i))});
    end
    checks++;
    if (log_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL busy_count: got %0d required %0d", log_q.size(), exp_q.size());
    end
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL busy_acc%0d: got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
    ram_lat = 0;
    start7(16'h1002);
    wait_end(k);
    @(negedge clk);
    checks++;
    if (log_q.size() != 2 || log_q[0].addr !== 32'h50 || log_q[1].addr !== 32'h10) begin
      failures++;
      $display("FAIL busy_regs_kept: got %0d accesses first %h required 2 at 50/10",
               log_q.size(), (log_q.size() > 0) ? log_q[0] : acc_t'(0));
    end
  endtask

  task automatic test_reset_abort;
    int k, n, e0;
    cr_write(2'd0, 16'h0200);
    cr_write(2'd1, 16'h0400);
    start7(16'h1006);
    n = 0;
    while (log_q.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (log_q.size() < 2) begin
      failures++;
      $display("FAIL abort_first_word: got %0d accesses required 2", log_q.size());
    end
    @(negedge clk);
    e0 = end_cnt;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({cr7_do, ram_a, ram_d, ram_req, ram_we, reg_a, reg_d, reg_req, reg_we, busy, dma_end} !== '0) begin
      failures++;
      $display("FAIL abort_outputs: got %h required 0", {cr7_do, ram_a, ram_d, ram_req, reg_a, reg_d, reg_req, busy, dma_end});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (end_cnt != e0) begin
      failures++;
      $display("FAIL abort_no_end: got %0d pulses required 0", end_cnt - e0);
    end
    start7(16'h1002);
    wait_end(k);
    checks++;
    if (k != 3) begin
      failures++;
      $display("FAIL abort_restart_time: got %0d required 3", k);
    end
    @(negedge clk);
    exp_q.push_back({1'b1, 1'b0, 32'h0, ram_val(19'h0)});
    exp_q.push_back({1'b0, 1'b1, 32'h0, ram_val(19'h0)});
    checks++;
    if (log_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL abort_restart_count: got %0d required %0d", log_q.size(), exp_q.size());
    end
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL abort_restart_acc%0d: got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram_to_reg();
    test_reg_to_ram();
    test_gate();
    test_wrap();
    test_zero_len();
    test_busy_write();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scsp_dma_ctrl.md
# scsp_dma_ctrl

Sound-side DMA sequencer for the SCSP. It moves a block of 16-bit words between sound RAM and the SCSP internal register space (slot regs, DSP MPRO/COEF/MADRS/TEMP/MEMS, etc.). It is configured through control registers CR5–CR7 (DMEAL/DMEAH, DRGA, DTLG, DEXE/DDIR/DGATE). It shares the sound RAM and register buses with slot/DSP/CPU traffic via an external arbiter (REQ/ACK), and raises the DMA-end interrupt source on completion.

## Interface
- RAM_AW, 19, sound RAM word-address width (DMEA = {DMEAH,DMEAL}, byte bits [19:1])
- REG_AW, 11, register word-address width (DRGA, byte bits [11:1])
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- CE  in  1  clock enable; all state/ACK sampling only on CLK edges with CE=1
- CR_WR  in  1  CPU control-register write strobe (one CE cycle)
- CR_SEL  in  2  0=CR5 (100412), 1=CR6 (100414), 2=CR7 (100416), 3=none
- CR_DI  in  16  write data
- CR7_DO  out  16  CR7 readback: {1'b0,DGATE,DDIR,DEXE,12'h000}
- RAM_A  out  RAM_AW  sound RAM word address
- RAM_D  out  16  RAM write data
- RAM_Q  in  16  RAM read data, valid with RAM_ACK
- RAM_REQ  out  1  RAM access request, held until ACK
- RAM_WE  out  1  1=write, 0=read; valid while RAM_REQ
- RAM_ACK  in  1  access complete
- REG_A  out  REG_AW  register word address
- REG_D  out  16  register write data
- REG_Q  in  16  register read data, valid with REG_ACK
- REG_REQ  out  1  register access request, held until ACK
- REG_WE  out  1  1=write, 0=read
- REG_ACK  in  1  access complete
- BUSY  out  1  transfer in progress (= DEXE)
- DMA_END  out  1  one-CE-cycle pulse at completion; feeds SCIPD/MCIPD bit 4

## Operation
- Write masks: CR5 FFFE (DMEAL=DI[15:1]), CR6 FFFE (DMEAH=DI[15:12], DRGA=DI[11:1]), CR7 7FFE (DGATE=DI[14], DDIR=DI[13], DEXE=DI[12], DTLG=DI[11:1]).
- While BUSY, all CR5–CR7 writes are ignored entirely. While idle, a CR7 write with DEXE=1 loads all CR7 fields and starts a transfer. A CR7 write with DEXE=0 only loads fields.
- Start copies DMEA→raddr, DRGA→gaddr, DTLG→count (word count).
- DDIR=0: source RAM[raddr] → dest REG[gaddr]. DDIR=1: source REG[gaddr] → dest RAM[raddr].
- DGATE=1: skip source reads and write 16'h0000 to the destination.
- FSM states:
  - IDLE: on start, go to DONE if count==0; else go to RD, or to WR if DGATE=1.
  - RD: source REQ, WE=0. On ACK, latch Q into data and go to WR.
  - WR: destination REQ, WE=1, D=data (0 if DGATE). On ACK: raddr+1, gaddr+1, count−1. If new count==0 go to DONE; else go to RD, or stay in WR if DGATE=1.
  - DONE: DMA_END=1, DEXE cleared, go to IDLE.
- Wrap rules: raddr wraps modulo 2^RAM_AW; gaddr wraps modulo 2^REG_AW; count never underflows.
- Only one REQ is active at a time. REQ, A, WE and D are stable from assertion until the ACK cycle inclusive. REQ deasserts in the cycle after ACK unless the next access targets the same bus.
- ACK is ignored when REQ is low.
- DMEA/DRGA/DTLG registers are not altered by a transfer; the working copies advance.

## Timing
- Reset values: all registers 0; state IDLE; every output 0 (CR7_DO=0, REQs 0, DMA_END 0, BUSY 0).
- Start write at CE edge N: BUSY=1 and the first REQ are asserted after edge N.
- ACK may arrive in the first REQ cycle. With zero-wait ACK, one word takes 2 CE cycles (1 with DGATE).
- DMA_END asserts 2·count+1 CE cycles after start (count+1 with DGATE, 1 for count 0). It lasts exactly one CE cycle, coincident with BUSY falling.
- A reset assertion mid-transfer aborts immediately: REQs drop asynchronously and no DMA_END pulse occurs.
- When CE=0, state, REQ and outputs hold.

## Test plan
- RAM→REG, DMEA=0x00100, DRGA=0x200, DTLG=3, zero-wait ACK:
  - RAM reads at 0x100, 0x101, 0x102 are followed by REG writes at 0x200, 0x201, 0x202 with matching data.
  - DMA_END is high 7 cycles after start; CR7_DO then reads 0x0000 (DDIR=0, DGATE=0).
- REG→RAM with DGATE=1, DTLG=2:
  - No REG reads occur.
  - RAM writes 0x0000 at DMEA and DMEA+1.
  - DMA_END fires 3 cycles after start.
- Wrap-around: DMEA=0x7FFFF, DRGA=0x7FF, DTLG=2:
  - Accesses go to RAM 0x7FFFF then 0x00000, and REG 0x7FF then 0x000.
- DTLG=0 with DEXE=1: no REQ is asserted and DMA_END pulses 1 cycle after start.
- Write while busy, with RAM_ACK delayed 3 cycles per access:
  - A CR5/CR6/CR7 write mid-transfer changes neither the addresses nor CR7_DO.
  - REQ, A and D stay stable until ACK.
  - Transfer length is unchanged.
- Mid-transfer reset after the first word, followed by a new start:
  - All outputs are 0 and BUSY=0 immediately, with no DMA_END.
  - The subsequent start behaves from clean register values.
